// File: rtl/ervp_cache_access_merger.sv
// rtl/ervp_cache_access_merger.sv - two-port access merger with in-order read reply routing
//
// Purpose:
//   Joins two single-beat access request ports onto one downstream port.
//   Conflicts are arbitrated round-robin. The port ID of each outstanding read
//   is held in a source-ID FIFO so that in-order replies return to their issuer.
//
// Configuration macro:
//   ERVP_CACHE_ACCESS_MERGER_FIXED_PRIORITY_EN
//     Defined:   port 0 always wins a conflict and no priority pointer exists.
//     Undefined: round-robin arbitration.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_clear               synchronous flush of the FIFO and the priority pointer
//   i_enable              0 blocks new grants; replies are still routed
//   o_busy                at least one read is outstanding
//   i/o_aN_rcq*           request port N (valid/ready, addr, write, wstrb, wdata)
//   o_aN_rcy*             reply port N (valid, rdata)
//   i/o_mem_scq*          merged downstream request port
//   i_mem_scy*            downstream reply port
module ervp_cache_access_merger #(
   parameter int BW_ADDR        = 32,
   parameter int BW_ACCESS      = 32,
   parameter int NUM_TXN_BUFFER = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   input  logic                   i_enable,
   output logic                   o_busy,
   output logic                   o_a0_rcqready,
   input  logic                   i_a0_rcqvalid,
   input  logic [BW_ADDR-1:0]     i_a0_rcqaddr,
   input  logic                   i_a0_rcqwrite,
   input  logic [BW_ACCESS/8-1:0] i_a0_rcqwstrb,
   input  logic [BW_ACCESS-1:0]   i_a0_rcqwdata,
   output logic                   o_a0_rcyvalid,
   output logic [BW_ACCESS-1:0]   o_a0_rcyrdata,
   output logic                   o_a1_rcqready,
   input  logic                   i_a1_rcqvalid,
   input  logic [BW_ADDR-1:0]     i_a1_rcqaddr,
   input  logic                   i_a1_rcqwrite,
   input  logic [BW_ACCESS/8-1:0] i_a1_rcqwstrb,
   input  logic [BW_ACCESS-1:0]   i_a1_rcqwdata,
   output logic                   o_a1_rcyvalid,
   output logic [BW_ACCESS-1:0]   o_a1_rcyrdata,
   input  logic                   i_mem_scqready,
   output logic                   o_mem_scqvalid,
   output logic [BW_ADDR-1:0]     o_mem_scqaddr,
   output logic                   o_mem_scqwrite,
   output logic [BW_ACCESS/8-1:0] o_mem_scqwstrb,
   output logic [BW_ACCESS-1:0]   o_mem_scqwdata,
   input  logic                   i_mem_scyvalid,
   input  logic [BW_ACCESS-1:0]   i_mem_scyrdata
);

   localparam int BW_PTR = (NUM_TXN_BUFFER > 1) ? $clog2(NUM_TXN_BUFFER) : 1;
   localparam int BW_CNT = $clog2(NUM_TXN_BUFFER + 1);
   localparam logic [BW_PTR-1:0] LAST_PTR = BW_PTR'(NUM_TXN_BUFFER - 1);
   localparam logic [BW_CNT-1:0] FULL_CNT = BW_CNT'(NUM_TXN_BUFFER);

   // one bit per entry: the port that issued the outstanding read
   logic [NUM_TXN_BUFFER-1:0] r_fifo;
   logic [BW_PTR-1:0]         r_rptr;
   logic [BW_PTR-1:0]         r_wptr;
   logic [BW_CNT-1:0]         r_count;

   logic w_empty, w_full;
   logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_any;
   logic w_sel_write, w_accept, w_acc_read;
   logic w_instant, w_pop, w_push, w_rsp_port, w_rsp_valid;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // a full FIFO blocks reads even when a reply pops in the same cycle
   assign w_elig0 = i_a0_rcqvalid & i_enable & ~i_rst & (i_a0_rcqwrite | ~w_full);
   assign w_elig1 = i_a1_rcqvalid & i_enable & ~i_rst & (i_a1_rcqwrite | ~w_full);

`ifdef ERVP_CACHE_ACCESS_MERGER_FIXED_PRIORITY_EN
   assign w_gnt1 = w_elig1 & ~w_elig0;
`else
   logic r_prio;
   assign w_gnt1 = w_elig1 & (~w_elig0 | r_prio);
`endif
   assign w_gnt0 = w_elig0 & ~w_gnt1;
   assign w_any  = w_gnt0 | w_gnt1;

   assign o_mem_scqvalid = w_any;
   assign o_mem_scqaddr  = w_gnt1 ? i_a1_rcqaddr  : i_a0_rcqaddr;
   assign o_mem_scqwrite = w_gnt1 ? i_a1_rcqwrite : i_a0_rcqwrite;
   assign o_mem_scqwstrb = w_gnt1 ? i_a1_rcqwstrb : i_a0_rcqwstrb;
   assign o_mem_scqwdata = w_gnt1 ? i_a1_rcqwdata : i_a0_rcqwdata;
   assign w_sel_write    = o_mem_scqwrite;

   assign o_a0_rcqready = w_gnt0 & i_mem_scqready;
   assign o_a1_rcqready = w_gnt1 & i_mem_scqready;

   assign w_accept   = w_any & i_mem_scqready;
   assign w_acc_read = w_accept & ~w_sel_write;

   // reply arriving together with the first read of an idle merger belongs to
   // that read; it bypasses the FIFO entirely
   assign w_instant = w_empty & i_mem_scyvalid & w_acc_read;
   assign w_pop     = ~w_empty & i_mem_scyvalid & ~i_rst;
   assign w_push    = w_acc_read & ~w_instant;

   assign w_rsp_port  = w_empty ? w_gnt1 : r_fifo[r_rptr];
   assign w_rsp_valid = w_pop | w_instant;

   assign o_a0_rcyvalid = w_rsp_valid & ~w_rsp_port;
   assign o_a1_rcyvalid = w_rsp_valid & w_rsp_port;
   assign o_a0_rcyrdata = i_mem_scyrdata;
   assign o_a1_rcyrdata = i_mem_scyrdata;

   assign o_busy = ~w_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
         end
         if (w_push) begin
            r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + BW_CNT'(1);
            2'b01:   r_count <= r_count - BW_CNT'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // entry storage needs no reset: entries are only read while counted valid
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= w_gnt1;
      end
   end

`ifndef ERVP_CACHE_ACCESS_MERGER_FIXED_PRIORITY_EN
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_prio <= 1'b0;
      end else if (w_accept) begin
         r_prio <= ~w_gnt1;
      end
   end
`endif

endmodule
